// File: rtl/tname_sprite_reader_if.sv
// ROM read bus between the banner reader and the 356x12 title/name ROM.
// Master drives the address; the slave returns data one clock later.
interface tname_sprite_reader_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/tname_sprite_reader.sv
// Title/name banner reader: beam hit test, ROM addressing, 2-cycle aligned pixel output
// and a typewriter-style reveal FSM. Optional colour-key transparency: TNAME_TRANSPARENT_EN.
module tname_sprite_reader #(
    parameter int         IMG_W       = 356,
    parameter int         IMG_H       = 12,
    parameter int         ADDR_W      = 13,
    parameter int         POS_X       = 142,
    parameter int         POS_Y       = 40,
    parameter int         REVEAL_STEP = 4,
    parameter logic [7:0] KEY         = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    input  logic                  i_active,
    input  logic                  i_frame_tick,
    input  logic                  i_start,
    input  logic                  i_clear,
    tname_sprite_reader_if.master rom,
    output logic [7:0]            o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REVEAL = 2'd1,
        S_SHOWN  = 2'd2
    } state_t;

`ifdef TNAME_TRANSPARENT_EN
    localparam logic TRANSP = 1'b1;
`else
    localparam logic TRANSP = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [8:0]        r_reveal_col;
    logic [8:0]        w_reveal_nxt;
    logic [9:0]        w_reveal_sum;
    logic [9:0]        w_col;
    logic [9:0]        w_row;
    logic              w_hit;
    logic              w_vis;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_hit1;
    logic              r_vis1;
    logic              r_hit2;
    logic              r_vis2;
    logic              w_key;
    logic              w_show;
    logic [7:0]        r_pixel;
    logic              r_pixel_valid;
    logic              r_done;

    // Row-major ROM index; row < IMG_H keeps the product in range, result truncated to ADDR_W.
    function automatic logic [ADDR_W-1:0] f_rom_index(input logic [9:0] row, input logic [9:0] col);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    // Underflowing subtractions wrap to large values and fail the range compares.
    assign w_col  = i_x - 10'(POS_X);
    assign w_row  = i_y - 10'(POS_Y);
    assign w_hit  = i_active & (w_col < 10'(IMG_W)) & (w_row < 10'(IMG_H));
    assign w_vis  = w_hit & (w_col < {1'b0, r_reveal_col});
    assign w_addr = f_rom_index(w_row, w_col);

    assign w_reveal_sum = {1'b0, r_reveal_col} + 10'(REVEAL_STEP);
    assign w_key        = TRANSP & (rom.rom_data == KEY);
    assign w_show       = r_hit2 & r_vis2 & ~w_key;

    // Reveal FSM next state: clear beats start, start beats frame tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_reveal_nxt = r_reveal_col;
        if (i_clear) begin
            w_state_nxt  = S_IDLE;
            w_reveal_nxt = 9'd0;
        end else if (i_start) begin
            w_state_nxt  = S_REVEAL;
            w_reveal_nxt = 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_reveal_nxt = 9'd0;
                end
                S_REVEAL: begin
                    if (i_frame_tick) begin
                        if (w_reveal_sum >= 10'(IMG_W)) begin
                            w_reveal_nxt = 9'(IMG_W);
                            w_state_nxt  = S_SHOWN;
                        end else begin
                            w_reveal_nxt = w_reveal_sum[8:0];
                        end
                    end else begin
                        w_reveal_nxt = r_reveal_col;
                    end
                end
                S_SHOWN: begin
                    w_reveal_nxt = 9'(IMG_W);
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_reveal_nxt = 9'd0;
                end
            endcase
        end
    end

    // Reveal FSM state, reveal column and registered done flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_reveal_col <= 9'd0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_reveal_col <= w_reveal_nxt;
            r_done       <= (r_state == S_SHOWN);
        end
    end

    // Address stage, flag stage aligned with ROM data, then registered pixel output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rom_addr    <= '0;
            r_hit1        <= 1'b0;
            r_vis1        <= 1'b0;
            r_hit2        <= 1'b0;
            r_vis2        <= 1'b0;
            r_pixel       <= 8'h00;
            r_pixel_valid <= 1'b0;
        end else begin
            r_rom_addr    <= w_hit ? w_addr : '0;
            r_hit1        <= w_hit;
            r_vis1        <= w_vis;
            r_hit2        <= r_hit1;
            r_vis2        <= r_vis1;
            r_pixel       <= w_show ? rom.rom_data : 8'h00;
            r_pixel_valid <= w_show;
        end
    end

    assign rom.rom_addr  = r_rom_addr;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;
    assign o_done        = r_done;

endmodule

// File: tb/tb_tname_sprite_reader.sv
// Scoreboard bench for tname_sprite_reader: expected pixels are queued when the beam
// is driven and compared when they emerge two cycles later.
module tb_tname_sprite_reader;

    typedef struct {
        int         due;
        logic       v;
        logic [7:0] p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       active, tick, start, clear;
    logic [7:0] pixel;
    logic       pv, done;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_st     = 0;   // 0 idle, 1 reveal, 2 shown
    int   m_rev    = 0;

    tname_sprite_reader_if #(.ADDR_W(13)) rom_if ();

    tname_sprite_reader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_active     (active),
        .i_frame_tick (tick),
        .i_start      (start),
        .i_clear      (clear),
        .rom          (rom_if),
        .o_pixel      (pixel),
        .o_pixel_valid(pv),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // ROM contents: word a = (a + 251) mod 256, so word 5 is 8'h00.
    function automatic logic [7:0] rom_word(input logic [12:0] a);
        logic [12:0] s;
        s = a + 13'd251;
        return s[7:0];
    endfunction

    always @(posedge clk) rom_if.rom_data <= rom_word(rom_if.rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick_clk();
        int   col, row, ea, pst;
        bit   hit, vis;
        exp_t e, f;
        col = int'(x) - 142;
        row = int'(y) - 40;
        hit = active && col >= 0 && col < 356 && row >= 0 && row < 12;
        vis = hit && col < m_rev;
        ea  = hit ? row * 356 + col : 0;
        e.v = vis;
        e.p = vis ? rom_word(13'(ea)) : 8'h00;
`ifdef TNAME_TRANSPARENT_EN
        if (vis && e.p == 8'h00) e.v = 1'b0;
`endif
        @(posedge clk);
        #1;
        cyc++;
        e.due = cyc + 2;
        pst = m_st;
        if (clear) begin
            m_st = 0; m_rev = 0;
        end else if (start) begin
            m_st = 1; m_rev = 0;
        end else if (tick && m_st == 1) begin
            m_rev = m_rev + 4;
            if (m_rev >= 356) begin
                m_rev = 356; m_st = 2;
            end
        end
        check_eq("done", {31'd0, done}, {31'd0, pst == 2});
        check_eq("rom_addr", {19'd0, rom_if.rom_addr}, ea);
        q.push_back(e);
        if (q[0].due == cyc) begin
            f = q.pop_front();
            check_eq("pixel_valid", {31'd0, pv}, {31'd0, f.v});
            check_eq("pixel", {24'd0, pixel}, {24'd0, f.p});
        end else begin
            check_eq("pixel_valid_idle", {31'd0, pv}, 32'd0);
        end
        start = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    task automatic probe(input int xx, input int yy);
        x = 10'(xx); y = 10'(yy); active = 1'b1;
        tick_clk();
        active = 1'b0;
        tick_clk();
        tick_clk();
    endtask

    task automatic sweep(input int yy, input int x0, input int x1);
        y = 10'(yy); active = 1'b1;
        for (int i = x0; i <= x1; i++) begin
            x = 10'(i);
            tick_clk();
        end
        active = 1'b0;
        tick_clk();
        tick_clk();
    endtask

    initial begin
        rst_n = 1'b0; x = 10'd0; y = 10'd0;
        active = 1'b0; tick = 1'b0; start = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_addr", {19'd0, rom_if.rom_addr}, 32'd0);
        check_eq("rst_pixel", {24'd0, pixel}, 32'd0);
        check_eq("rst_valid", {31'd0, pv}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // IDLE: banner hidden even on an in-region beam
        x = 10'd142; y = 10'd40; active = 1'b1;
        repeat (4) tick_clk();
        active = 1'b0;

        start = 1'b1;
        tick_clk();
        for (int n = 1; n <= 90; n++) begin
            tick = 1'b1;
            tick_clk();
            tick_clk();
            if (n == 2) sweep(40, 138, 154);
        end

        // SHOWN: corners, just-outside, inactive beam, key-valued word 5
        probe(142, 40);
        probe(497, 51);
        probe(498, 51);
        probe(141, 40);
        probe(147, 40);
        probe(300, 45);
        probe(142, 52);
        x = 10'd142; y = 10'd40; active = 1'b0;
        tick_clk();

        // clear + start together: clear wins, so ticks no longer reveal
        clear = 1'b1; start = 1'b1;
        tick_clk();
        tick_clk();
        tick = 1'b1;
        tick_clk();
        probe(142, 40);

        // back to SHOWN, then a lone start restarts the reveal from column 0
        start = 1'b1;
        tick_clk();
        repeat (89) begin
            tick = 1'b1;
            tick_clk();
        end
        tick_clk();
        probe(497, 51);
        start = 1'b1;
        tick_clk();
        tick_clk();
        probe(142, 40);

        // reveal 8 columns, hold the beam on a visible pixel, then reset mid-line
        tick = 1'b1; tick_clk();
        tick = 1'b1; tick_clk();
        x = 10'd142; y = 10'd40; active = 1'b1;
        repeat (3) tick_clk();
        check_eq("pre_reset_valid", {31'd0, pv}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midline_rst_valid", {31'd0, pv}, 32'd0);
        check_eq("midline_rst_pixel", {24'd0, pixel}, 32'd0);
        check_eq("midline_rst_addr", {19'd0, rom_if.rom_addr}, 32'd0);
        q.delete();
        m_st = 0; m_rev = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick_clk();
        tick = 1'b1;
        tick_clk();
        probe(142, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
